// File: rtl/lcd_cmd_sequencer.sv
// rtl/lcd_cmd_sequencer.sv - command FIFO and issue sequencer for the image display controller
// Queues host commands and issues them one at a time; write-out (code 0) is terminal until reset.
module lcd_cmd_sequencer #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    host_cmd,
  input  logic          host_push,
  output logic          host_full,
  output logic [AW:0]   host_count,
  input  logic          lcd_busy,
  input  logic          lcd_done,
  output logic [3:0]    lcd_cmd,
  output logic          lcd_cmd_valid,
  output logic [7:0]    issued_cnt,
  output logic          seq_done,
  output logic          err_illegal,
  output logic          err_overflow,
  output logic          err_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_ACK, WAIT_IDLE, WRITE, FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [3:0]    cmd_q, cmd_d;
  logic          valid_q, valid_d;
  logic [7:0]    issued_q, issued_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          seq_done_q, seq_done_d;
  logic          ill_q, ill_d, ovf_q, ovf_d, tmo_err_q, tmo_err_d;
  logic          full, pop, accept, legal;

  assign full  = (count_q == FULL_CNT);
  assign legal = (host_cmd < 4'd12);

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    valid_d    = valid_q;
    issued_d   = issued_q;
    tmo_d      = tmo_q;
    seq_done_d = seq_done_q;
    tmo_err_d  = tmo_err_q;
    pop        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (count_q != '0 && !lcd_busy) begin
          pop     = 1'b1;
          cmd_d   = mem_q[rd_ptr_q];
          valid_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cmd_d    = 4'd0;
        valid_d  = 1'b0;
        issued_d = (issued_q == 8'hFF) ? issued_q : issued_q + 8'd1;
        tmo_d    = '0;
        state_d  = (cmd_q == 4'd0) ? WRITE : WAIT_ACK;
      end
      WAIT_ACK: begin
        if (lcd_busy) begin
          state_d = WAIT_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          tmo_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (!lcd_busy) state_d = IDLE;
      end
      WRITE: begin
        if (lcd_done) begin
          seq_done_d = 1'b1;
          state_d    = FINISH;
        end
      end
      FINISH: begin
        state_d = FINISH;
      end
      default: state_d = IDLE;
    endcase

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    accept = host_push && legal && (!full || pop);
    ill_d  = ill_q | (host_push && !legal);
    ovf_d  = ovf_q | (host_push && legal && full && !pop);

    wr_ptr_d = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (accept && !pop)      count_d = count_q + 1'b1;
    else if (pop && !accept) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cmd_q      <= 4'd0;
      valid_q    <= 1'b0;
      issued_q   <= 8'd0;
      tmo_q      <= '0;
      seq_done_q <= 1'b0;
      ill_q      <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cmd_q      <= cmd_d;
      valid_q    <= valid_d;
      issued_q   <= issued_d;
      tmo_q      <= tmo_d;
      seq_done_q <= seq_done_d;
      ill_q      <= ill_d;
      ovf_q      <= ovf_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && accept) mem_q[wr_ptr_q] <= host_cmd;
  end

  assign host_full     = full;
  assign host_count    = count_q;
  assign lcd_cmd       = cmd_q;
  assign lcd_cmd_valid = valid_q;
  assign issued_cnt    = issued_q;
  assign seq_done      = seq_done_q;
  assign err_illegal   = ill_q;
  assign err_overflow  = ovf_q;
  assign err_timeout   = tmo_err_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb/tb_lcd_cmd_sequencer.sv - self-checking bench for lcd_cmd_sequencer
// Queue-based reference model plus a small busy/ack controller model.
module tb_lcd_cmd_sequencer;
  localparam int DEPTH = 8;
  localparam int MODE_HOLD = 0, MODE_ACK = 1, MODE_MUTE = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] host_cmd;
  logic       host_push;
  logic       host_full;
  logic [3:0] host_count;
  logic       lcd_busy, lcd_done;
  logic [3:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic [7:0] issued_cnt;
  logic       seq_done, err_illegal, err_overflow, err_timeout;

  lcd_cmd_sequencer #(.DEPTH(8), .AW(3), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .host_cmd(host_cmd), .host_push(host_push),
    .host_full(host_full), .host_count(host_count),
    .lcd_busy(lcd_busy), .lcd_done(lcd_done),
    .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid),
    .issued_cnt(issued_cnt), .seq_done(seq_done),
    .err_illegal(err_illegal), .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference model state
  int q[$];
  bit exp_ill, exp_ovf, exp_tmo, exp_seq, in_write, tmo_open, prev_valid;
  int exp_issued, cyc, last_issue, tmo_t, write_cycles;
  // controller model state
  int mode, busy_left;
  bit pending;

  task automatic clear_model();
    q.delete();
    exp_ill = 0; exp_ovf = 0; exp_tmo = 0; exp_seq = 0;
    in_write = 0; tmo_open = 0; exp_issued = 0; last_issue = -100;
  endtask

  task automatic set_mode(input int m);
    mode = m; busy_left = 0; pending = 0;
    lcd_busy = (m == MODE_HOLD);
  endtask

  task automatic step(input bit push, input logic [3:0] code, input bit done);
    bit pre_busy;
    int e;
    host_push = push; host_cmd = code; lcd_done = done;
    pre_busy = lcd_busy;
    @(posedge clk); #1;
    cyc++;
    host_push = 1'b0; lcd_done = 1'b0;
    if (reset) begin
      clear_model();
      check("valid_in_reset", lcd_cmd_valid, 0);
    end else begin
      if (done && in_write && write_cycles >= 1) exp_seq = 1;
      if (in_write) write_cycles++;
      // one issue cycle, then TIMEOUT wait cycles sampling busy
      if (tmo_open) begin
        tmo_t++;
        if (tmo_t >= 2 && pre_busy) tmo_open = 0;
        else if (tmo_t == 17) begin exp_tmo = 1; tmo_open = 0; end
      end
      if (prev_valid && exp_issued < 255) exp_issued++;
      if (lcd_cmd_valid) begin
        check("issue_when_busy", pre_busy, 0);
        check("issue_spacing", (cyc - last_issue) >= 4, 1);
        check("issue_after_write", in_write, 0);
        last_issue = cyc;
        if (q.size() == 0) begin
          check("issue_from_empty", 1, 0);
        end else begin
          e = q.pop_front();
          check("issue_order", lcd_cmd, e);
          if (e == 0) begin in_write = 1; write_cycles = 0; end
          else begin tmo_open = 1; tmo_t = 0; end
        end
      end
      if (push) begin
        if (code >= 12) exp_ill = 1;
        else if (q.size() < DEPTH) q.push_back(int'(code));
        else exp_ovf = 1;
      end
    end
    if (!lcd_cmd_valid) check("cmd_zero_idle", lcd_cmd, 0);
    check("host_count", host_count, q.size());
    check("host_full", host_full, q.size() == DEPTH);
    check("issued_cnt", issued_cnt, exp_issued);
    check("err_illegal", err_illegal, exp_ill);
    check("err_overflow", err_overflow, exp_ovf);
    check("err_timeout", err_timeout, exp_tmo);
    check("seq_done", seq_done, exp_seq);
    // controller: busy rises the cycle after it samples valid
    if (busy_left > 0) busy_left--;
    if (pending) begin busy_left = $urandom_range(1, 3); pending = 0; end
    if (lcd_cmd_valid) pending = 1;
    case (mode)
      MODE_HOLD: lcd_busy = 1'b1;
      MODE_ACK:  lcd_busy = (busy_left > 0);
      default:   lcd_busy = 1'b0;
    endcase
    prev_valid = lcd_cmd_valid;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) step(0, 4'd0, 0);
    reset = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin step(0, 4'd0, 0); n++; end
    check("drain_empty", q.size(), 0);
    repeat (8) step(0, 4'd0, 0);
  endtask

  initial begin
    int n;
    int codes[4] = '{5, 7, 9, 10};
    host_push = 0; host_cmd = 0; lcd_done = 0; prev_valid = 0; cyc = 0;
    clear_model();
    set_mode(MODE_HOLD);
    do_reset();

    // busy held after reset blocks the first issue
    step(1, 4'd1, 0);
    repeat (63) step(0, 4'd0, 0);
    check("s1_no_issue", issued_cnt, 0);
    set_mode(MODE_ACK);
    wait_drain(20);
    check("s1_issued", issued_cnt, 1);

    foreach (codes[i]) step(1, 4'(codes[i]), 0);
    wait_drain(60);
    check("s2_issued", issued_cnt, 5);
    check("s2_count", host_count, 0);

    // overflow, then push coinciding with the first pop from a full FIFO
    set_mode(MODE_HOLD);
    for (int i = 0; i < 9; i++) step(1, 4'($urandom_range(1, 11)), 0);
    check("s3_count", host_count, 8);
    check("s3_full", host_full, 1);
    check("s3_ovf", err_overflow, 1);
    set_mode(MODE_ACK);
    step(1, 4'd6, 0);
    check("s3_count_after", host_count, 8);

    step(1, 4'd13, 0);
    check("s4_illegal", err_illegal, 1);

    // silent controller: every issue times out, queue still drains
    set_mode(MODE_MUTE);
    n = 0;
    while (!err_timeout && n < 100) begin step(0, 4'd0, 0); n++; end
    check("s5_timeout", err_timeout, 1);
    n = 0;
    while (!lcd_cmd_valid && n < 10) begin step(0, 4'd0, 0); n++; end
    check("s5_next_issue", lcd_cmd_valid, 1);
    set_mode(MODE_ACK);
    wait_drain(400);

    // randomized traffic, stray lcd_done pulses must be ignored
    do_reset();
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 2) == 0, 4'($urandom_range(1, 15)), $urandom_range(0, 19) == 0);
    wait_drain(600);

    // write-out is terminal
    step(1, 4'd2, 0);
    step(1, 4'd0, 0);
    step(1, 4'd4, 0);
    n = 0;
    while (!in_write && n < 40) begin step(0, 4'd0, 0); n++; end
    repeat (10) step(0, 4'd0, 0);
    check("s6_left", host_count, 1);
    check("s6_not_done", seq_done, 0);
    step(0, 4'd0, 1);
    check("s6_done", seq_done, 1);
    repeat (5) step(0, 4'd0, 0);
    check("s6_done_held", seq_done, 1);
    do_reset();
    check("s6_rst_done", seq_done, 0);
    check("s6_rst_count", host_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
